// File: rtl/uart_xcvr_pkg.sv
// Shared types, legality limits and parity helper for the uart_xcvr serial engine.
// Parity hardware is present only when UART_PARITY_EN is defined.
package uart_xcvr_pkg;

    localparam int unsigned MinDataWidth  = 5;
    localparam int unsigned MaxDataWidth  = 9;
    localparam int unsigned MinOversample = 8;
    localparam int unsigned MaxOversample = 32;

`ifdef UART_PARITY_EN
    localparam bit ParityPresent = 1'b1;
`else
    localparam bit ParityPresent = 1'b0;
`endif

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BRKWAIT
    } rx_state_e;

    function automatic logic par(input logic [MaxDataWidth-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_xcvr_rx.sv
// Receive path: 2-flop synchroniser, mid-bit sampling FSM with break detection,
// and a ready/valid hold register with overflow and error event pulses.
module uart_xcvr_rx
    import uart_xcvr_pkg::*;
#(
    parameter int unsigned DataWidth  = 8,
    parameter int unsigned Oversample = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 tick,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    input  logic                 rx_i,
    input  logic                 rx_ready_i,
    output logic                 rx_valid_o,
    output logic [DataWidth-1:0] rx_data_o,
    output logic                 rx_frame_err_o,
    output logic                 rx_parity_err_o,
    output logic                 rx_break_o,
    output logic                 rx_overflow_o
);
    // state      | meaning
    // RX_IDLE    | waiting for a low line
    // RX_START   | half bit to the start-bit centre, rejects false starts
    // RX_DATA    | sampling data bits, LSB first
    // RX_PARITY  | sampling the parity bit
    // RX_STOP    | sampling the stop bit
    // RX_BRKWAIT | break seen, waiting for the line to return high
    localparam int unsigned CntW = $clog2(Oversample);
    localparam int unsigned BitW = $clog2(DataWidth);

    rx_state_e            state_q, state_d;
    logic [1:0]           sync_q;
    logic                 rx_s;
    logic [CntW-1:0]      cnt_q;
    logic [BitW-1:0]      bit_q;
    logic [DataWidth-1:0] shift_q;
    logic                 all_zero_q, par_bad_q;
    logic                 half_pt, bit_pt, last_bit, stop_pt, brk, frame_done, ovf;

    assign rx_s       = sync_q[1];
    assign half_pt    = tick && (cnt_q == CntW'(Oversample/2 - 1));
    assign bit_pt     = tick && (cnt_q == CntW'(Oversample - 1));
    assign last_bit   = (bit_q == BitW'(DataWidth - 1));
    assign stop_pt    = (state_q == RX_STOP) && bit_pt;
    assign brk        = stop_pt && !rx_s && all_zero_q;
    assign frame_done = stop_pt && !brk;
    assign ovf        = frame_done && rx_valid_o && !rx_ready_i;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RX_IDLE:    if (!rx_s) state_d = RX_START;
            RX_START:   if (half_pt) state_d = rx_s ? RX_IDLE : RX_DATA;
            RX_DATA:    if (bit_pt && last_bit) state_d = parity_en ? RX_PARITY : RX_STOP;
            RX_PARITY:  if (bit_pt) state_d = RX_STOP;
            RX_STOP:    if (bit_pt) state_d = brk ? RX_BRKWAIT : RX_IDLE;
            RX_BRKWAIT: if (rx_s) state_d = RX_IDLE;
            default:    state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= RX_IDLE;
            sync_q          <= 2'b11;
            cnt_q           <= '0;
            bit_q           <= '0;
            shift_q         <= '0;
            all_zero_q      <= 1'b0;
            par_bad_q       <= 1'b0;
            rx_valid_o      <= 1'b0;
            rx_data_o       <= '0;
            rx_frame_err_o  <= 1'b0;
            rx_parity_err_o <= 1'b0;
            rx_break_o      <= 1'b0;
            rx_overflow_o   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= {sync_q[0], rx_i};
            if (state_q == RX_IDLE) begin
                cnt_q <= '0;
            end else if (tick) begin
                if (state_q == RX_START && half_pt) begin
                    // re-phase the counter so later samples land mid-bit
                    cnt_q      <= '0;
                    bit_q      <= '0;
                    all_zero_q <= 1'b1;
                    par_bad_q  <= 1'b0;
                end else begin
                    cnt_q <= cnt_q + CntW'(1);
                end
                if (bit_pt && state_q == RX_DATA) begin
                    shift_q    <= {rx_s, shift_q[DataWidth-1:1]};
                    all_zero_q <= all_zero_q & ~rx_s;
                    bit_q      <= last_bit ? '0 : bit_q + BitW'(1);
                end
                if (bit_pt && state_q == RX_PARITY) begin
                    par_bad_q  <= rx_s ^ par(MaxDataWidth'(shift_q), parity_odd);
                    all_zero_q <= all_zero_q & ~rx_s;
                end
            end

            rx_frame_err_o  <= stop_pt && !rx_s;
            rx_break_o      <= brk;
            rx_overflow_o   <= ovf;
            rx_parity_err_o <= frame_done && par_bad_q && ParityPresent;
            if (frame_done && !ovf) begin
                rx_data_o  <= shift_q;
                rx_valid_o <= 1'b1;
            end else if (rx_valid_o && rx_ready_i) begin
                rx_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/uart_xcvr.sv
// Parametrised UART transceiver: NCO baud generator, transmit FSM, and receive path.
// Define UART_PARITY_EN to include parity generation and checking.
module uart_xcvr
    import uart_xcvr_pkg::*;
#(
    parameter int unsigned DataWidth  = 8,
    parameter int unsigned Oversample = 16,
    parameter int unsigned NcoWidth   = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NcoWidth-1:0]  nco_i,
    input  logic                 stop2_i,
    input  logic                 parity_en_i,
    input  logic                 parity_odd_i,
    input  logic                 tx_valid_i,
    input  logic [DataWidth-1:0] tx_data_i,
    output logic                 tx_ready_o,
    output logic                 tx_o,
    output logic                 tx_busy_o,
    input  logic                 rx_i,
    input  logic                 rx_ready_i,
    output logic                 rx_valid_o,
    output logic [DataWidth-1:0] rx_data_o,
    output logic                 rx_frame_err_o,
    output logic                 rx_parity_err_o,
    output logic                 rx_break_o,
    output logic                 rx_overflow_o
);
    // state     | meaning
    // TX_IDLE   | line high, ready for a character
    // TX_START  | start bit (low)
    // TX_DATA   | data bits, LSB first
    // TX_PARITY | parity bit
    // TX_STOP   | one or two stop bits (high)
    localparam int unsigned CntW = $clog2(Oversample);
    localparam int unsigned BitW = $clog2(DataWidth);

    if (DataWidth < MinDataWidth || DataWidth > MaxDataWidth) begin : g_bad_data_width
        $error("uart_xcvr: DataWidth must be in 5..9");
    end
    if (Oversample < MinOversample || Oversample > MaxOversample ||
        (Oversample & (Oversample - 1)) != 0) begin : g_bad_oversample
        $error("uart_xcvr: Oversample must be a power of two in 8..32");
    end

    logic [NcoWidth-1:0]  acc_q;
    logic [NcoWidth:0]    acc_sum;
    logic                 tick;

    assign acc_sum = {1'b0, acc_q} + {1'b0, nco_i};
    assign tick    = acc_sum[NcoWidth];

    tx_state_e            tx_state_q, tx_state_d;
    logic [CntW-1:0]      tx_cnt_q;
    logic [BitW-1:0]      tx_bit_q;
    logic [DataWidth-1:0] tx_shift_q;
    logic                 tx_stop2_q, tx_par_en_q, tx_par_q;
    logic                 tx_bit_end, tx_accept;

    assign tx_bit_end = tick && (tx_cnt_q == CntW'(Oversample - 1));
    assign tx_accept  = tx_valid_i && tx_ready_o;
    assign tx_ready_o = (tx_state_q == TX_IDLE);
    assign tx_busy_o  = (tx_state_q != TX_IDLE);

    always_comb begin
        tx_state_d = tx_state_q;
        tx_o       = 1'b1;
        unique case (tx_state_q)
            TX_IDLE:   if (tx_valid_i) tx_state_d = TX_START;
            TX_START: begin
                tx_o = 1'b0;
                if (tx_bit_end) tx_state_d = TX_DATA;
            end
            TX_DATA: begin
                tx_o = tx_shift_q[0];
                if (tx_bit_end && tx_bit_q == BitW'(DataWidth - 1))
                    tx_state_d = tx_par_en_q ? TX_PARITY : TX_STOP;
            end
            TX_PARITY: begin
                tx_o = tx_par_q;
                if (tx_bit_end) tx_state_d = TX_STOP;
            end
            TX_STOP:   if (tx_bit_end && !(tx_stop2_q && tx_bit_q == '0)) tx_state_d = TX_IDLE;
            default:   tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q       <= '0;
            tx_state_q  <= TX_IDLE;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_shift_q  <= '0;
            tx_stop2_q  <= 1'b0;
            tx_par_en_q <= 1'b0;
            tx_par_q    <= 1'b0;
        end else begin
            acc_q      <= acc_sum[NcoWidth-1:0];
            tx_state_q <= tx_state_d;
            if (tx_accept) begin
                tx_shift_q  <= tx_data_i;
                tx_cnt_q    <= '0;
                tx_bit_q    <= '0;
                tx_stop2_q  <= stop2_i;
                tx_par_en_q <= parity_en_i & ParityPresent;
                tx_par_q    <= par(MaxDataWidth'(tx_data_i), parity_odd_i);
            end else if (tick && tx_state_q != TX_IDLE) begin
                // counter wraps at Oversample, so no explicit clear between bits
                tx_cnt_q <= tx_cnt_q + CntW'(1);
                if (tx_bit_end && tx_state_q == TX_DATA) begin
                    tx_shift_q <= tx_shift_q >> 1;
                    tx_bit_q   <= (tx_bit_q == BitW'(DataWidth - 1)) ? '0 : tx_bit_q + BitW'(1);
                end else if (tx_bit_end && tx_state_q == TX_STOP) begin
                    tx_bit_q <= tx_bit_q + BitW'(1);
                end
            end
        end
    end

    uart_xcvr_rx #(
        .DataWidth (DataWidth),
        .Oversample(Oversample)
    ) u_rx (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .tick           (tick),
        .parity_en      (parity_en_i & ParityPresent),
        .parity_odd     (parity_odd_i),
        .rx_i           (rx_i),
        .rx_ready_i     (rx_ready_i),
        .rx_valid_o     (rx_valid_o),
        .rx_data_o      (rx_data_o),
        .rx_frame_err_o (rx_frame_err_o),
        .rx_parity_err_o(rx_parity_err_o),
        .rx_break_o     (rx_break_o),
        .rx_overflow_o  (rx_overflow_o)
    );

endmodule
